// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared constants and next-value helpers for the counters library
package counters_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough for any legal WIDTH plus one guard bit, so MODULUS==2**WIDTH never overflows.
    localparam int CNT_MAX_W = 32;
    typedef logic [CNT_MAX_W:0] cnt_t;

    function automatic cnt_t clamp_load(input cnt_t d, input cnt_t modulus);
        return (d >= modulus) ? modulus - cnt_t'(1) : d;
    endfunction

    function automatic cnt_t mod_next(input cnt_t q, input logic dir, input cnt_t modulus);
        if (dir == DIR_UP) begin
            return (q == modulus - cnt_t'(1)) ? cnt_t'(0) : q + cnt_t'(1);
        end
        return (q == cnt_t'(0)) ? modulus - cnt_t'(1) : q - cnt_t'(1);
    endfunction

endpackage

// File: rtl/updown_next.sv
// rtl/updown_next.sv - next count value and limit detect for one up/down stage (SYNC_UPDOWN_SATURATE_EN selects saturation)
module updown_next
    import counters_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             M,
    output logic [WIDTH-1:0] nxt,
    output logic             at_lim
);

    cnt_t q_ext;
    cnt_t top_val;
    cnt_t step_val;

    assign q_ext    = cnt_t'(q);
    assign top_val  = cnt_t'(MODULUS) - cnt_t'(1);
    assign step_val = mod_next(q_ext, M, cnt_t'(MODULUS));

    assign at_lim = (M == DIR_UP) ? (q_ext == top_val) : (q_ext == cnt_t'(0));

`ifdef SYNC_UPDOWN_SATURATE_EN
    assign nxt = at_lim ? q : WIDTH'(step_val);
`else
    assign nxt = WIDTH'(step_val);
`endif

endmodule

// File: rtl/sync_updown_mod.sv
// rtl/sync_updown_mod.sv - parametrised up/down counter with load, enable, tc and wrap (SYNC_UPDOWN_SATURATE_EN)
module sync_updown_mod
    import counters_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             M,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] nxt;
    logic             at_lim;

    updown_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q      (q_q),
        .M      (M),
        .nxt    (nxt),
        .at_lim (at_lim)
    );

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = WIDTH'(clamp_load(cnt_t'(d), cnt_t'(MODULUS)));
        end else if (en) begin
            q_d = nxt;
`ifdef SYNC_UPDOWN_SATURATE_EN
            wrap_d = 1'b0;
`else
            wrap_d = at_lim;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= WIDTH'(RST_VAL);
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // tc anticipates the wrap/limit on the coming edge; it feeds the next stage's en.
    assign tc   = en & ~load & at_lim;
    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_mod.sv
// tb/tb_sync_updown_mod.sv - directed scoreboard bench for sync_updown_mod (WIDTH=4, MODULUS=10)
module tb_sync_updown_mod;

    logic       clk = 1'b0;
    logic       rst, M, en, load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap;

    logic       c_rst, c_M, c_en, c_load;
    logic [3:0] c_d;
    logic [3:0] u_q, t_q;
    logic       u_tc, t_tc, u_wrap, t_wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] q;
        logic       w;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sync_updown_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .M(M), .en(en), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap)
    );

    sync_updown_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) units (
        .clk(clk), .rst(c_rst), .M(c_M), .en(c_en), .load(c_load), .d(c_d),
        .q(u_q), .tc(u_tc), .wrap(u_wrap)
    );

    sync_updown_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) tens (
        .clk(clk), .rst(c_rst), .M(c_M), .en(u_tc), .load(c_load), .d(c_d),
        .q(t_q), .tc(t_tc), .wrap(t_wrap)
    );

    task automatic step(input string tag, input logic r, input logic e, input logic m,
                        input logic ld, input logic [3:0] dv,
                        input logic [3:0] eq, input logic ew,
                        input logic chk_tc, input logic etc);
        exp_t ex;
        exp_t got;
        rst = r; en = e; M = m; load = ld; d = dv;
        ex.q = eq; ex.w = ew; ex.tag = tag;
        sb.push_back(ex);
        #1;
        if (chk_tc) begin
            total++;
            assert (tc === etc) else begin
                bad++;
                $error("FAIL %s tc got=%b exp=%b", tag, tc, etc);
            end
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        assert (q === got.q) else begin
            bad++;
            $error("FAIL %s q got=%0d exp=%0d", got.tag, q, got.q);
        end
        total++;
        assert (wrap === got.w) else begin
            bad++;
            $error("FAIL %s wrap got=%b exp=%b", got.tag, wrap, got.w);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; M = 1'b1; load = 1'b0; d = '0;
        c_rst = 1'b0; c_M = 1'b1; c_en = 1'b0; c_load = 1'b0; c_d = '0;
        @(negedge clk);

        // tag, rst, en, M, load, d, exp_q, exp_wrap, chk_tc, exp_tc
        step("rst0",     1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0);
        step("rst1",     1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0);
        step("rel_up",   1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b1, 1'b0);

`ifndef SYNC_UPDOWN_SATURATE_EN
        step("ld8",      1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  4'd8, 1'b0, 1'b1, 1'b0);
        step("up9",      1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0);
        step("upwrap",   1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1);
        step("up1",      1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b1, 1'b0);

        step("ld1",      1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  4'd1, 1'b0, 1'b1, 1'b0);
        step("dn0",      1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0);
        step("dnwrap",   1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1, 1'b1);
        step("revwrap",  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1);

        step("ld3",      1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0, 1'b1, 1'b0);
        step("rev_up",   1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd4, 1'b0, 1'b1, 1'b0);
        step("rev_dn",   1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd3, 1'b0, 1'b1, 1'b0);

        step("clamp",    1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold",  1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0);
        end
        // Reset while a wrap is predicted must discard the step and the pending pulse.
        step("rst_mid",  1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1);
        step("ld_max",   1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  4'd9, 1'b0, 1'b1, 1'b0);

        c_rst = 1'b0;
        @(posedge clk); #1;
        c_rst = 1'b1; c_en = 1'b1; c_M = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        total++;
        assert (u_q === 4'd5) else begin bad++; $error("FAIL casc_up_units got=%0d exp=5", u_q); end
        total++;
        assert (t_q === 4'd2) else begin bad++; $error("FAIL casc_up_tens got=%0d exp=2", t_q); end
        c_M = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        total++;
        assert (u_q === 4'd9) else begin bad++; $error("FAIL casc_dn_units got=%0d exp=9", u_q); end
        total++;
        assert (t_q === 4'd9) else begin bad++; $error("FAIL casc_dn_tens got=%0d exp=9", t_q); end
`else
        step("ld8",      1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  4'd8, 1'b0, 1'b1, 1'b0);
        step("sat_up9",  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0);
        step("sat_upA",  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b1);
        step("sat_upB",  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b1);
        step("ld1",      1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  4'd1, 1'b0, 1'b1, 1'b0);
        step("sat_dn0",  1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0);
        step("sat_dnA",  1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1);
        step("sat_dnB",  1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1);
        step("clamp",    1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0, 1'b1, 1'b0);
`endif

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
